uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmitter that consumes the single-cycle baud tick from the team's baud clock divider.
- Buffers bytes from the CPU-side write interface in a small FIFO and serialises them on `tx`.
- Frame format: LSB-first, one start bit, DATA_BITS data bits, optional parity bit, STOP_BITS stop bits.
- Sits between the memory-mapped UART register write path and the board TX pin.

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- FIFO_DEPTH, 4: FIFO entries; must be a power of 2, minimum 2.
- STOP_BITS, 1: stop bits per frame; 1 or 2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; used only when UART_PARITY_EN is defined.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- baud_tick  in  1  baud-rate strobe from the divider; every cycle it is high counts as one tick.
- tx_data  in  DATA_BITS  byte to transmit.
- tx_valid  in  1  write request.
- tx_ready  out  1  FIFO not full (combinational from the FIFO count).
- tx  out  1  serial line; idles high; registered.
- busy  out  1  high when state != IDLE or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (asynchronous): tx=1, state=IDLE, FIFO empty, fifo_count=0, busy=0, tx_ready=1, bit counter=0, shift register=0.
- Push: on a clk edge where tx_valid && tx_ready, tx_data is written at the write pointer. Pointers wrap modulo FIFO_DEPTH.
- Push when full: tx_ready=0, so the write is dropped silently. A same-cycle pop does not make room for a write in that cycle.
- Push and pop in the same cycle (FIFO not full): count is unchanged and both pointers advance.
- State transitions happen only on clk edges where baud_tick=1. With baud_tick=0, all frame state holds. FIFO pushes are independent of baud_tick.
- IDLE:
  - FIFO empty: tx=1, stay in IDLE.
  - FIFO non-empty on a tick: pop the head into the shift register, tx<=0, go to START.
- START, on a tick: tx<=shift[0], shift right, bitcnt<=1, go to DATA.
- DATA, on a tick:
  - bitcnt<DATA_BITS: tx<=shift[0], shift right, bitcnt++.
  - bitcnt==DATA_BITS: go to PARITY if enabled, else tx<=1 and go to STOP with stopcnt=1.
- STOP, on a tick:
  - stopcnt<STOP_BITS: stopcnt++ and tx stays 1.
  - Otherwise, FIFO non-empty: pop, tx<=0, go to START. Frames are back-to-back with no idle gap.
  - Otherwise, FIFO empty: go to IDLE with tx=1.
- Latency: a byte written to an empty FIFO while in IDLE drives tx low on the clk edge of the first baud_tick after the write. A tick in the same cycle as the push does not start the frame, because the pop sees the pre-push count.
- Each bit is held for exactly one tick period. A full frame without parity lasts 1+DATA_BITS+STOP_BITS tick periods.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronous), the FIFO contents are discarded, and no partial frame resumes after reset release.

Optional Feature:
- UART_PARITY_EN defined:
  - A PARITY state follows DATA.
  - On the tick that ends the last data bit, tx<=^data (even parity) or ~^data (PARITY_ODD=1). The byte's parity is latched at pop time.
  - On the next tick, tx<=1 and go to STOP.
  - Frame length is 2+DATA_BITS+STOP_BITS.
- UART_PARITY_EN undefined:
  - No PARITY state and no parity logic synthesised.
  - PARITY_ODD is ignored.

Test Plan:
- Reset: hold rst for 3 cycles -> tx=1, tx_ready=1, busy=0, fifo_count=0; after release with no writes, tx stays 1 for 200 cycles.
- Single byte 0xA5, baud_tick every 10 cycles -> tx sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each value held exactly 10 cycles; busy drops on the tick ending the stop bit.
- Overflow: write 0x01,0x02,0x03,0x04,0x05 on consecutive cycles with no tick -> fifo_count=4, tx_ready=0, 0x05 lost; then 4 back-to-back frames over 40 tick periods with no idle bit between them.
- Push/pop collision: fifo_count=2 and a write coincides with the tick that pops -> fifo_count stays 2 and the byte order is preserved.
- Reset mid-frame: send 0xFF and assert rst after the 3rd data bit -> tx=1 in the same cycle, fifo_count=0, no further low bit after release.
- Parity (UART_PARITY_EN): 0x07 with PARITY_ODD=0 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame is 11 tick periods. With the macro undefined, the frame is 10 tick periods.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter; one frame bit per baud_tick period, LSB first.
// Defining UART_PARITY_EN adds a parity bit between the data and stop bits.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          baud_tick,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_tx: illegal parameter set");
    end

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    logic par_q, par_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
    logic [1:0]           stopcnt_q, stopcnt_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 push_s, pop_s, has_data_s;
    logic [DATA_BITS-1:0] head_s;

    assign has_data_s = (count_q != {CNT_W{1'b0}});
    assign head_s     = mem_q[rd_ptr_q];
    assign tx_ready   = (count_q != CNT_W'(FIFO_DEPTH));
    assign push_s     = tx_valid && tx_ready;
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || has_data_s;
    assign fifo_count = count_q;

    // Frame sequencer: everything advances only on baud ticks.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        stopcnt_d = stopcnt_q;
        pop_s     = 1'b0;
`ifdef UART_PARITY_EN
        par_d     = par_q;
`endif
        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (has_data_s) begin
                        pop_s   = 1'b1;
                        shift_d = head_s;
                        tx_d    = 1'b0;
                        state_d = S_START;
`ifdef UART_PARITY_EN
                        par_d   = parity_of(head_s);
`endif
                    end else begin
                        tx_d = 1'b1;
                    end
                end
                S_START: begin
                    tx_d     = shift_q[0];
                    shift_d  = shift_q >> 1;
                    bitcnt_d = BIT_W'(1);
                    state_d  = S_DATA;
                end
                S_DATA: begin
                    if (bitcnt_q < BIT_W'(DATA_BITS)) begin
                        tx_d     = shift_q[0];
                        shift_d  = shift_q >> 1;
                        bitcnt_d = bitcnt_q + BIT_W'(1);
                    end else begin
`ifdef UART_PARITY_EN
                        tx_d      = par_q;
                        state_d   = S_PARITY;
`else
                        tx_d      = 1'b1;
                        stopcnt_d = 2'd1;
                        state_d   = S_STOP;
`endif
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    tx_d      = 1'b1;
                    stopcnt_d = 2'd1;
                    state_d   = S_STOP;
                end
`endif
                S_STOP: begin
                    if (stopcnt_q < 2'(STOP_BITS)) begin
                        stopcnt_d = stopcnt_q + 2'd1;
                    end else if (has_data_s) begin
                        // Next frame starts immediately: no idle bit between frames.
                        pop_s   = 1'b1;
                        shift_d = head_s;
                        tx_d    = 1'b0;
                        state_d = S_START;
`ifdef UART_PARITY_EN
                        par_d   = parity_of(head_s);
`endif
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FIFO next state; pop decision above uses the pre-push occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = tx_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State, line and FIFO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            shift_q   <= {DATA_BITS{1'b0}};
            bitcnt_q  <= {BIT_W{1'b0}};
            stopcnt_q <= 2'd0;
            mem_q     <= '{default: {DATA_BITS{1'b0}}};
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
`ifdef UART_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            stopcnt_q <= stopcnt_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
`ifdef UART_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule
